// File: rtl/gate_sensor_conditioner_pkg.sv
// gate_sensor_conditioner_pkg: channel state encoding and default timing constants.
package gate_sensor_conditioner_pkg;
  typedef enum logic [1:0] {CLEAR, BLOCKED, STUCK} chan_state_e;
  localparam int DEF_DEBOUNCE_CYCLES  = 50000;
  localparam int DEF_MIN_BLOCK_CYCLES = 250000;
  localparam int DEF_STUCK_CYCLES     = 500000000;
endpackage

// File: rtl/gate_sensor_conditioner_if.sv
// gate_sensor_conditioner_if: raw sensor inputs and conditioned outputs for both gate channels.
interface gate_sensor_conditioner_if;
  logic entry_n;
  logic exit_n;
  logic entry_pulse;
  logic exit_pulse;
  logic entry_blocked;
  logic exit_blocked;
  logic entry_stuck;
  logic exit_stuck;
  modport master (
    output entry_n, exit_n,
    input  entry_pulse, exit_pulse, entry_blocked, exit_blocked, entry_stuck, exit_stuck
  );
  modport slave (
    input  entry_n, exit_n,
    output entry_pulse, exit_pulse, entry_blocked, exit_blocked, entry_stuck, exit_stuck
  );
endinterface

// File: rtl/sensor_channel.sv
// sensor_channel: synchronizer, debouncer, pass/stuck FSM and dwell counter for one IR sensor.
module sensor_channel
  import gate_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_BLOCK_CYCLES = DEF_MIN_BLOCK_CYCLES,
  parameter int STUCK_CYCLES     = DEF_STUCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n_i,
  output logic pulse_o,
  output logic blocked_o,
  output logic stuck_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(STUCK_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] MIN_V    = DW'(MIN_BLOCK_CYCLES);
  localparam logic [DW-1:0] STK_LAST = DW'(STUCK_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 1 || MIN_BLOCK_CYCLES < 1 || MIN_BLOCK_CYCLES >= STUCK_CYCLES) begin : g_bad_params
    $error("sensor_channel: illegal DEBOUNCE/MIN_BLOCK/STUCK parameters");
  end
  logic [1:0] sync_q;
  logic sync_v, flip;
  logic deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dwell_q;
  chan_state_e state_q;
  logic pulse_q, stuck_q;
  assign sync_v = sync_q[1];
  // a level change is accepted on the last of DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    flip  = (sync_v != deb_q) && (cnt_q == DEB_LAST);
    cnt_d = (sync_v == deb_q || flip) ? '0 : cnt_q + CW'(1);
    deb_d = flip ? sync_v : deb_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      state_q <= CLEAR;
      dwell_q <= '0;
      pulse_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_n_i};
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pulse_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          if (!deb_q) begin
            state_q <= BLOCKED;
            dwell_q <= '0;
          end
        end
        BLOCKED: begin
          if (deb_q) begin
            state_q <= CLEAR;
            pulse_q <= dwell_q >= MIN_V;
          end else begin
            dwell_q <= dwell_q + DW'(1);
            if (dwell_q == STK_LAST) begin
              state_q <= STUCK;
              stuck_q <= 1'b1;
            end
          end
        end
        STUCK: begin
          if (deb_q) begin
            state_q <= CLEAR;
            stuck_q <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end
  assign pulse_o   = pulse_q;
  assign blocked_o = ~deb_q;
  assign stuck_o   = stuck_q;
endmodule

// File: rtl/gate_sensor_conditioner.sv
// gate_sensor_conditioner: two independent entry/exit IR sensor channels.
module gate_sensor_conditioner
  import gate_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_BLOCK_CYCLES = DEF_MIN_BLOCK_CYCLES,
  parameter int STUCK_CYCLES     = DEF_STUCK_CYCLES
) (
  input logic clk,
  input logic rst,
  gate_sensor_conditioner_if.slave bus
);
  sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MIN_BLOCK_CYCLES(MIN_BLOCK_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_entry (
    .clk(clk),
    .rst(rst),
    .raw_n_i(bus.entry_n),
    .pulse_o(bus.entry_pulse),
    .blocked_o(bus.entry_blocked),
    .stuck_o(bus.entry_stuck)
  );
  sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MIN_BLOCK_CYCLES(MIN_BLOCK_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_exit (
    .clk(clk),
    .rst(rst),
    .raw_n_i(bus.exit_n),
    .pulse_o(bus.exit_pulse),
    .blocked_o(bus.exit_blocked),
    .stuck_o(bus.exit_stuck)
  );
endmodule

// File: tb/tb_gate_sensor_conditioner.sv
// tb_gate_sensor_conditioner: directed and random sensor traffic checked against a duration-based model.
module tb_gate_sensor_conditioner;
  localparam int DEB = 4, MINB = 8, STK = 32, MAXE = 4000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  gate_sensor_conditioner_if bus ();
  gate_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .MIN_BLOCK_CYCLES(MINB),
    .STUCK_CYCLES(STK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, e = 0, rst_edge = -1;
  bit raw_h[2][MAXE];
  bit deb_m[2], blk[2], fall_p[2], rel_p[2];
  int b_e[2], c_e[2], pcnt[2], plast[2];
  bit blk_seen[2], stuck_seen[2];
  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask
  task automatic chk_i(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask
  // raw sample taken at edge k; reset forces the synchronizer history to unblocked
  function automatic bit reff(int ch, int k);
    return (k < 0 || k <= rst_edge) ? 1'b1 : raw_h[ch][k];
  endfunction
  // debounced level flips once the last DEB synchronized samples all disagree with it;
  // a pass is judged by how long the channel sat in its blocked state
  task automatic model(input int ch, output bit pl, output bit bl, output bit st);
    bit nd;
    bit all_diff;
    int dwell;
    nd = deb_m[ch];
    all_diff = 1'b1;
    for (int j = 2; j <= DEB + 1; j++) if (reff(ch, e - j) == deb_m[ch]) all_diff = 1'b0;
    if (all_diff) nd = !deb_m[ch];
    pl = 1'b0;
    if (rel_p[ch]) begin
      rel_p[ch] = 1'b0;
      blk[ch] = 1'b0;
      dwell = c_e[ch] - b_e[ch] - 1;
      pl = (dwell >= MINB) && (dwell < STK);
    end
    if (fall_p[ch]) begin
      fall_p[ch] = 1'b0;
      blk[ch] = 1'b1;
    end
    if (deb_m[ch] && !nd) begin
      b_e[ch] = e;
      fall_p[ch] = 1'b1;
    end
    if (!deb_m[ch] && nd) begin
      c_e[ch] = e;
      rel_p[ch] = 1'b1;
    end
    st = blk[ch] && (e - b_e[ch] - 1 >= STK);
    bl = !nd;
    deb_m[ch] = nd;
  endtask
  task automatic tick(input logic en, input logic xn, input logic r);
    bit pl[2], bl[2], st[2];
    bus.entry_n = en;
    bus.exit_n = xn;
    rst = r;
    @(posedge clk);
    e++;
    raw_h[0][e] = en;
    raw_h[1][e] = xn;
    for (int ch = 0; ch < 2; ch++) begin
      if (r) begin
        deb_m[ch] = 1'b1; blk[ch] = 1'b0; fall_p[ch] = 1'b0; rel_p[ch] = 1'b0;
        pl[ch] = 1'b0; bl[ch] = 1'b0; st[ch] = 1'b0;
      end else begin
        model(ch, pl[ch], bl[ch], st[ch]);
      end
    end
    if (r) rst_edge = e;
    #1;
    chk("entry_pulse", bus.entry_pulse, pl[0]);
    chk("exit_pulse", bus.exit_pulse, pl[1]);
    chk("entry_blocked", bus.entry_blocked, bl[0]);
    chk("exit_blocked", bus.exit_blocked, bl[1]);
    chk("entry_stuck", bus.entry_stuck, st[0]);
    chk("exit_stuck", bus.exit_stuck, st[1]);
    if (bus.entry_pulse) begin pcnt[0]++; plast[0] = e; end
    if (bus.exit_pulse) begin pcnt[1]++; plast[1] = e; end
    blk_seen[0] |= bus.entry_blocked;
    blk_seen[1] |= bus.exit_blocked;
    stuck_seen[0] |= bus.entry_stuck;
    stuck_seen[1] |= bus.exit_stuck;
  endtask
  task automatic clr();
    for (int ch = 0; ch < 2; ch++) begin
      pcnt[ch] = 0; plast[ch] = -1; blk_seen[ch] = 1'b0; stuck_seen[ch] = 1'b0;
    end
  endtask
  task automatic run(input logic en, input logic xn, input logic r, input int n);
    for (int i = 0; i < n; i++) tick(en, xn, r);
  endtask
  initial begin
    int start;
    int rem[2];
    bit lvl[2];
    bit rr;
    for (int ch = 0; ch < 2; ch++) begin deb_m[ch] = 1'b1; blk[ch] = 1'b0; fall_p[ch] = 1'b0; rel_p[ch] = 1'b0; end
    clr();
    run(1, 1, 1, 3);
    run(1, 1, 0, 8);
    // valid entry pass and release-to-pulse latency
    clr();
    run(0, 1, 0, 20);
    start = e;
    run(1, 1, 0, 10);
    chk_i("pass_count", pcnt[0], 1);
    chk_i("pass_latency", plast[0] - start, 7);
    chk_i("pass_blocked_seen", int'(blk_seen[0]), 1);
    // short exit glitch
    clr();
    run(1, 0, 0, 3);
    run(1, 1, 0, 10);
    chk_i("glitch_blocked", int'(blk_seen[1]), 0);
    chk_i("glitch_pulse", pcnt[1], 0);
    // dwell 6 rejected, dwell 8 accepted
    clr();
    run(0, 1, 0, 7);
    run(1, 1, 0, 10);
    chk_i("short_block_pulse", pcnt[0], 0);
    clr();
    run(0, 1, 0, 9);
    run(1, 1, 0, 10);
    chk_i("min_block_pulse", pcnt[0], 1);
    // dwell 31 still a pass, long block goes stuck
    clr();
    run(1, 0, 0, 32);
    run(1, 1, 0, 10);
    chk_i("dwell31_pulse", pcnt[1], 1);
    chk_i("dwell31_stuck", int'(stuck_seen[1]), 0);
    clr();
    run(1, 0, 0, 50);
    chk("stuck_set", bus.exit_stuck, 1'b1);
    run(1, 1, 0, 10);
    chk("stuck_clear", bus.exit_stuck, 1'b0);
    chk_i("stuck_pulse", pcnt[1], 0);
    // simultaneous release
    clr();
    run(0, 0, 0, 15);
    run(1, 1, 0, 10);
    chk_i("both_entry", pcnt[0], 1);
    chk_i("both_exit", pcnt[1], 1);
    chk_i("both_same_cycle", plast[0], plast[1]);
    // reset mid-block aborts the pass
    clr();
    run(0, 1, 0, 15);
    run(0, 1, 1, 2);
    run(0, 1, 0, 5);
    run(1, 1, 0, 12);
    chk_i("reset_abort_pulse", pcnt[0], 0);
    // reset released onto a held-low sensor still yields a normal pass
    clr();
    run(0, 1, 1, 2);
    run(0, 1, 0, 20);
    run(1, 1, 0, 10);
    chk_i("reset_held_low_pass", pcnt[0], 1);
    // random independent traffic on both channels
    for (int ch = 0; ch < 2; ch++) begin rem[ch] = 0; lvl[ch] = 1'b1; end
    for (int i = 0; i < 1200; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = !lvl[ch];
          if (lvl[ch]) rem[ch] = $urandom_range(14, 1);
          else case ($urandom_range(2, 0))
            0: rem[ch] = $urandom_range(5, 1);
            1: rem[ch] = $urandom_range(20, 6);
            default: rem[ch] = $urandom_range(45, 30);
          endcase
        end
        rem[ch]--;
      end
      rr = ($urandom_range(299, 0) == 0);
      tick(lvl[0], lvl[1], rr);
    end
    run(1, 1, 0, 60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
